// File: rtl/fifo_pkg.sv
// Shared defaults for the asynchronous FIFO read-side blocks.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int OUT_DEPTH_DEF  = 2;

    // Occupancy counters need one extra bit to represent a completely full buffer.
    function automatic int lvl_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_outbuf.sv
// Small circular output buffer: register-based entries, wrapping pointers and
// an occupancy count. Read data is presented combinationally from the read pointer.
module fifo_rd_outbuf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_DEPTH  = OUT_DEPTH_DEF,
    parameter int LVL_W      = lvl_width(OUT_DEPTH)
) (
    input  logic                  Rclk,
    input  logic                  Rrst,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0]      level
);

    localparam int PTR_W = $clog2(OUT_DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] occ_q, occ_d;
    logic [OUT_DEPTH-1:0][DATA_WIDTH-1:0] entries;

    genvar gi;
    generate
        for (gi = 0; gi < OUT_DEPTH; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_q, entry_d;

            always_comb begin
                entry_d = entry_q;
                if (capture && (wr_ptr_q == PTR_W'(gi))) begin
                    entry_d = wr_data;
                end
            end

            always_ff @(posedge Rclk or negedge Rrst) begin
                if (!Rrst) begin
                    entry_q <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign entries[gi] = entry_q;
        end
    endgenerate

    // Flush only rewinds the bookkeeping; entry contents are left stale on purpose.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(capture);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        occ_d    = occ_q + LVL_W'(capture) - LVL_W'(pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end
    end

    always_ff @(posedge Rclk or negedge Rrst) begin
        if (!Rrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign rd_data = entries[rd_ptr_q];
    assign level   = occ_q;

endmodule

// File: rtl/fifo_rd_stream_out.sv
// Read-side unloader: pops the async FIFO whenever the output buffer has room
// and forwards the words as a valid/ready stream.
module fifo_rd_stream_out
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_DEPTH  = OUT_DEPTH_DEF,
    parameter int LVL_W      = lvl_width(OUT_DEPTH)
) (
    input  logic                  Rclk,
    input  logic                  Rrst,
    input  logic                  Rempty,
    output logic                  Rinc,
    input  logic [DATA_WIDTH-1:0] Rdata,
    input  logic                  Flush,
    output logic                  Out_valid,
    output logic [DATA_WIDTH-1:0] Out_data,
    input  logic                  Out_ready,
    output logic [LVL_W-1:0]      Out_level
);

    logic             inflight_q, inflight_d;
    logic             pop;
    logic             capture;
    logic [LVL_W:0]   pending;

    // Words already committed (buffered + one in flight) minus the one leaving now
    // must stay below the depth before another pop from the FIFO is allowed.
    always_comb begin
        Out_valid  = (Out_level != '0) & ~Flush;
        pop        = Out_valid & Out_ready;
        capture    = inflight_q & ~Flush;
        pending    = {1'b0, Out_level} + (LVL_W+1)'(inflight_q) - (LVL_W+1)'(pop);
        Rinc       = Rrst & ~Rempty & ~Flush & (pending < (LVL_W+1)'(OUT_DEPTH));
        inflight_d = Rinc;
    end

    always_ff @(posedge Rclk or negedge Rrst) begin
        if (!Rrst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_rd_outbuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_DEPTH  (OUT_DEPTH),
        .LVL_W      (LVL_W)
    ) u_outbuf (
        .Rclk    (Rclk),
        .Rrst    (Rrst),
        .capture (capture),
        .wr_data (Rdata),
        .pop     (pop),
        .flush   (Flush),
        .rd_data (Out_data),
        .level   (Out_level)
    );

endmodule

// File: tb/tb_fifo_rd_stream_out.sv
// Scoreboard bench for fifo_rd_stream_out with a behavioural FIFO model on the read side.
module tb_fifo_rd_stream_out;

    localparam int DW    = 8;
    localparam int DEPTH = 2;
    localparam int LW    = 2;

    logic          Rclk;
    logic          Rrst;
    logic          Rempty;
    logic          Rinc;
    logic [DW-1:0] Rdata;
    logic          Flush;
    logic          Out_valid;
    logic [DW-1:0] Out_data;
    logic          Out_ready;
    logic [LW-1:0] Out_level;

    fifo_rd_stream_out #(
        .DATA_WIDTH (DW),
        .OUT_DEPTH  (DEPTH),
        .LVL_W      (LW)
    ) dut (
        .Rclk      (Rclk),
        .Rrst      (Rrst),
        .Rempty    (Rempty),
        .Rinc      (Rinc),
        .Rdata     (Rdata),
        .Flush     (Flush),
        .Out_valid (Out_valid),
        .Out_data  (Out_data),
        .Out_ready (Out_ready),
        .Out_level (Out_level)
    );

    initial Rclk = 1'b0;
    always #5 Rclk = ~Rclk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_m[$];
    logic [DW-1:0] exp_q[$];

    logic          s_rinc, s_vld, s_rdy, s_pop;
    logic [DW-1:0] s_dat;
    logic [LW-1:0] s_lvl;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat   = '0;

    // One Rclk cycle: sample at the falling edge, then advance the FIFO model.
    task automatic cycle();
        logic [DW-1:0] fetched;
        logic [DW-1:0] expw;
        fetched = 8'hEE;
        @(negedge Rclk);
        s_rinc = Rinc;
        s_vld  = Out_valid;
        s_rdy  = Out_ready;
        s_dat  = Out_data;
        s_lvl  = Out_level;
        s_pop  = s_vld & s_rdy;
        if (s_rinc === 1'b1) begin
            checks++;
            if (Rempty !== 1'b0 || fifo_m.size() == 0) begin
                errors++;
                $display("FAIL rinc_when_empty: Rinc=%b with Rempty=%b, required Rinc=0", s_rinc, Rempty);
            end else begin
                fetched = fifo_m.pop_front();
            end
        end
        if (prev_stall && !Flush) begin
            checks++;
            if (s_vld !== 1'b1 || s_dat !== prev_dat) begin
                errors++;
                $display("FAIL stall_hold: valid=%b data=%h, required valid=1 data=%h", s_vld, s_dat, prev_dat);
            end
        end
        if (s_pop) begin
            $display("pop data=%h level=%0d", s_dat, s_lvl);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop: data=%h, required no transfer", s_dat);
            end else begin
                expw = exp_q.pop_front();
                if (s_dat !== expw) begin
                    errors++;
                    $display("FAIL pop_data: data=%h, required %h", s_dat, expw);
                end
            end
        end
        checks++;
        if ($isunknown(s_lvl) || s_lvl > LW'(DEPTH)) begin
            errors++;
            $display("FAIL level_range: level=%0d, required <= %0d", s_lvl, DEPTH);
        end
        prev_stall = s_vld & ~s_rdy & ~Flush;
        prev_dat   = s_dat;
        @(posedge Rclk);
        #1;
        Rdata  = fetched;
        Rempty = (fifo_m.size() == 0);
    endtask

    task automatic push_word(input logic [DW-1:0] w, input bit expect_out);
        fifo_m.push_back(w);
        if (expect_out) exp_q.push_back(w);
        Rempty = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() > 0; i++) cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        Rrst = 1'b0; Rempty = 1'b1; Flush = 1'b0; Out_ready = 1'b0; Rdata = '0;
        #2;
        checks++;
        if ({Rinc, Out_valid, Out_data, Out_level} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rinc=%b valid=%b data=%h level=%0d, required all 0",
                     Rinc, Out_valid, Out_data, Out_level);
        end
        @(posedge Rclk); #1;
        Rrst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (s_rinc !== 1'b0 || s_vld !== 1'b0 || s_lvl !== '0) begin
                errors++;
                $display("FAIL idle_empty: rinc=%b valid=%b level=%0d, required 0 0 0", s_rinc, s_vld, s_lvl);
            end
        end
    endtask

    task automatic test_stream();
        int rinc_idx[16];
        int pop_idx[16];
        int rn = 0;
        int pn = 0;
        logic [DW-1:0] words[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        Out_ready = 1'b1;
        foreach (words[k]) push_word(words[k], 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_rinc && rn < 16) rinc_idx[rn++] = i;
            if (s_pop && pn < 16) pop_idx[pn++] = i;
        end
        checks++;
        if (rn != 4 || rinc_idx[3] - rinc_idx[0] != 3) begin
            errors++;
            $display("FAIL stream_rinc: %0d pulses, required 4 consecutive", rn);
        end
        checks++;
        if (pn != 4 || pop_idx[0] != rinc_idx[0] + 2 || pop_idx[3] - pop_idx[0] != 3) begin
            errors++;
            $display("FAIL stream_latency: %0d pops first at %0d, required 4 consecutive from %0d",
                     pn, pop_idx[0], rinc_idx[0] + 2);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_left: %0d undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        int rn = 0;
        int pop_idx[16];
        int pn = 0;
        Out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) push_word(DW'(k * 8'h11), 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (s_rinc) rn++;
        end
        checks++;
        if (rn != 2) begin
            errors++;
            $display("FAIL bp_rinc_count: %0d pulses, required 2", rn);
        end
        checks++;
        if (s_lvl !== LW'(2) || s_vld !== 1'b1 || s_dat !== 8'h11) begin
            errors++;
            $display("FAIL bp_hold: level=%0d valid=%b data=%h, required 2 1 11", s_lvl, s_vld, s_dat);
        end
        Out_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
            cycle();
            if (s_pop && pn < 16) pop_idx[pn++] = i;
        end
        checks++;
        if (pn != 6 || pop_idx[5] - pop_idx[0] != 5) begin
            errors++;
            $display("FAIL bp_refill_gap: %0d pops span %0d, required 6 consecutive", pn, pop_idx[5] - pop_idx[0]);
        end
    endtask

    task automatic test_toggle();
        for (int k = 0; k < 5; k++) push_word(8'hA1 + DW'(k), 1'b1);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            Out_ready = (i % 2 == 0);
            cycle();
        end
        Out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL toggle_delivery: %0d undelivered, required 0", exp_q.size());
        end
    endtask

    task automatic test_flush();
        Out_ready = 1'b0;
        push_word(8'h51, 1'b0);
        push_word(8'h52, 1'b0);
        cycle();
        checks++;
        if (s_rinc !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup_rinc1: rinc=%b, required 1", s_rinc);
        end
        cycle();
        checks++;
        if (s_rinc !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup_rinc2: rinc=%b, required 1", s_rinc);
        end
        Flush = 1'b1;
        cycle();
        checks++;
        if (s_lvl !== LW'(1) || s_vld !== 1'b0 || s_rinc !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: level=%0d valid=%b rinc=%b, required 1 0 0", s_lvl, s_vld, s_rinc);
        end
        Flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (s_lvl !== '0 || s_vld !== 1'b0) begin
                errors++;
                $display("FAIL flush_after: level=%0d valid=%b, required 0 0", s_lvl, s_vld);
            end
        end
        Out_ready = 1'b1;
        push_word(8'h5C, 1'b1);
        drain(10);
    endtask

    task automatic test_reset_mid();
        Out_ready = 1'b0;
        push_word(8'h71, 1'b0);
        push_word(8'h72, 1'b0);
        push_word(8'h73, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        checks++;
        if (Out_level !== LW'(2)) begin
            errors++;
            $display("FAIL rst_mid_setup: level=%0d, required 2", Out_level);
        end
        Rrst = 1'b0;
        #1;
        checks++;
        if ({Rinc, Out_valid, Out_data, Out_level} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: rinc=%b valid=%b data=%h level=%0d, required all 0",
                     Rinc, Out_valid, Out_data, Out_level);
        end
        fifo_m.delete();
        exp_q.delete();
        prev_stall = 1'b0;
        Rempty = 1'b1;
        @(posedge Rclk); #1;
        Rrst = 1'b1;
        Out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (s_vld !== 1'b0 || s_lvl !== '0) begin
                errors++;
                $display("FAIL rst_mid_stale: valid=%b level=%0d, required 0 0", s_vld, s_lvl);
            end
        end
        push_word(8'h7A, 1'b1);
        drain(10);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
